conv_feeder: RTL and testbench

Stream source for the ConvTop input port. On a start command it reads KernelSize weight beats from a weight RAM and then row×col pixel beats from a data RAM, and drives them onto weight_in/weight_valid and data_in/data_valid in ConvTop's expected order: weights first, then pixels in raster order, four channels per beat. It sits between the on-chip buffers and ConvTop and replaces bench-driven stimulus in the integrated design.

---
 rtl/conv_feeder.sv | 128 ++++++++++++
 tb/tb_conv_feeder.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_feeder.sv
// Stream source for ConvTop: fetches KernelSize weight beats, then row*col pixel beats.
// Optional idle gap between the two phases is enabled by defining CONV_FEEDER_GAP_EN.
`timescale 1ns/1ps

module conv_feeder #(
  parameter int unsigned DataWidth  = 64,
  parameter int unsigned KernelSize = 9,
  parameter int unsigned AddrWidth  = 18,
  parameter int unsigned PhaseGap   = 4
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic                     start,
  input  logic [8:0]               row_in,
  input  logic [8:0]               col_in,
  output logic                     w_ren,
  output logic [3:0]               w_addr,
  input  logic [4*DataWidth-1:0]   w_rdata,
  output logic                     d_ren,
  output logic [AddrWidth-1:0]     d_addr,
  input  logic [4*DataWidth-1:0]   d_rdata,
  output logic [4*DataWidth-1:0]   weight_out,
  output logic                     weight_valid,
  output logic [4*DataWidth-1:0]   data_out,
  output logic                     data_valid,
  output logic                     busy,
  output logic                     done
);

  // One counter serves both the weight index and the gap length.
  localparam int unsigned CntMax = (KernelSize > PhaseGap) ? KernelSize : PhaseGap;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

`ifdef CONV_FEEDER_GAP_EN
  typedef enum logic [2:0] {IDLE, LOAD_W, GAP, LOAD_D, FIN} state_t;
`else
  typedef enum logic [2:0] {IDLE, LOAD_W, LOAD_D, FIN} state_t;
`endif

  state_t               state;
  logic [CntW-1:0]      cnt;
  logic [AddrWidth-1:0] dcnt;
  logic [8:0]           row_q;
  logic [8:0]           col_q;
  logic [AddrWidth-1:0] total_c;

  // Full-width product so 511x511 does not truncate.
  assign total_c = AddrWidth'(row_q) * AddrWidth'(col_q);

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state        <= IDLE;
      cnt          <= '0;
      dcnt         <= '0;
      row_q        <= '0;
      col_q        <= '0;
      w_ren        <= 1'b0;
      w_addr       <= '0;
      d_ren        <= 1'b0;
      d_addr       <= '0;
      weight_out   <= '0;
      weight_valid <= 1'b0;
      data_out     <= '0;
      data_valid   <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      // Read enables default low; the RAM data is captured one cycle after each enable.
      w_ren        <= 1'b0;
      d_ren        <= 1'b0;
      weight_valid <= w_ren;
      weight_out   <= w_ren ? w_rdata : '0;
      data_valid   <= d_ren;
      data_out     <= d_ren ? d_rdata : '0;
      busy         <= (state != IDLE);
      done         <= data_valid & ~d_ren;

      case (state)
        IDLE: begin
          // busy still covers the final data beat after FIN returns here.
          if (start && !busy && (row_in != 9'd0) && (col_in != 9'd0)) begin
            row_q <= row_in;
            col_q <= col_in;
            cnt   <= '0;
            dcnt  <= '0;
            state <= LOAD_W;
          end
        end
        LOAD_W: begin
          w_ren  <= 1'b1;
          w_addr <= 4'(cnt);
          if (cnt == CntW'(KernelSize - 1)) begin
            cnt <= '0;
`ifdef CONV_FEEDER_GAP_EN
            state <= GAP;
`else
            state <= LOAD_D;
`endif
          end else begin
            cnt <= cnt + CntW'(1);
          end
        end
`ifdef CONV_FEEDER_GAP_EN
        GAP: begin
          if (cnt == CntW'(PhaseGap - 1)) begin
            cnt   <= '0;
            state <= LOAD_D;
          end else begin
            cnt <= cnt + CntW'(1);
          end
        end
`endif
        LOAD_D: begin
          d_ren  <= 1'b1;
          d_addr <= dcnt;
          if (dcnt == total_c - AddrWidth'(1)) begin
            state <= FIN;
          end else begin
            dcnt <= dcnt + AddrWidth'(1);
          end
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_feeder.sv
// Scoreboard bench for conv_feeder: expected beats queued at start, checked as the DUT emits them.
`timescale 1ns/1ps

module tb_conv_feeder;

  localparam int unsigned DW = 64;
  localparam int unsigned K  = 9;
  localparam int unsigned AW = 18;
  localparam int unsigned PG = 4;
  localparam int unsigned BW = 4 * DW;
`ifdef CONV_FEEDER_GAP_EN
  localparam int GAPC = PG;
`else
  localparam int GAPC = 0;
`endif

  logic          Clk = 1'b0;
  logic          Rst = 1'b0;
  logic          start = 1'b0;
  logic [8:0]    row_in = '0;
  logic [8:0]    col_in = '0;
  logic          w_ren;
  logic [3:0]    w_addr;
  logic [BW-1:0] w_rdata;
  logic          d_ren;
  logic [AW-1:0] d_addr;
  logic [BW-1:0] d_rdata;
  logic [BW-1:0] weight_out;
  logic          weight_valid;
  logic [BW-1:0] data_out;
  logic          data_valid;
  logic          busy;
  logic          done;

  typedef struct {
    int            cyc;
    logic [BW-1:0] val;
  } exp_t;

  exp_t wq[$];
  exp_t dq[$];
  int   done_q[$];
  int   ecnt = 0;
  int   blo = 1;
  int   bhi = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  conv_feeder #(.DataWidth(DW), .KernelSize(K), .AddrWidth(AW), .PhaseGap(PG)) dut (
    .Clk(Clk), .Rst(Rst), .start(start), .row_in(row_in), .col_in(col_in),
    .w_ren(w_ren), .w_addr(w_addr), .w_rdata(w_rdata),
    .d_ren(d_ren), .d_addr(d_addr), .d_rdata(d_rdata),
    .weight_out(weight_out), .weight_valid(weight_valid),
    .data_out(data_out), .data_valid(data_valid),
    .busy(busy), .done(done)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) ecnt <= ecnt + 1;

  function automatic logic [BW-1:0] wbeat(input int i);
    return {4{DW'(i)}};
  endfunction

  function automatic logic [BW-1:0] pix(input int p);
    logic [BW-1:0] v;
    for (int k = 0; k < 4; k++) v[k*DW +: DW] = DW'(4 * p + k);
    return v;
  endfunction

  // RAM models: combinational read, all-ones when not enabled so unmasked capture shows up.
  always_comb begin
    w_rdata = '1;
    if (w_ren) w_rdata = wbeat(int'(w_addr));
  end

  always_comb begin
    d_rdata = '1;
    if (d_ren) d_rdata = pix(int'(d_addr));
  end

  task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Output monitor: pops expected beats as valids appear and flags late, early or stray beats.
  always @(negedge Clk) begin
    exp_t e;
    chk("busy", busy, (ecnt >= blo && ecnt <= bhi));
    chk("valid_overlap", weight_valid & data_valid, 1'b0);
    while (wq.size() > 0 && wq[0].cyc < ecnt) begin
      chk("w_beat_missing_cyc", ecnt, wq[0].cyc);
      void'(wq.pop_front());
    end
    while (dq.size() > 0 && dq[0].cyc < ecnt) begin
      chk("d_beat_missing_cyc", ecnt, dq[0].cyc);
      void'(dq.pop_front());
    end
    while (done_q.size() > 0 && done_q[0] < ecnt) begin
      chk("done_missing_cyc", ecnt, done_q[0]);
      void'(done_q.pop_front());
    end
    if (weight_valid) begin
      if (wq.size() == 0) chk("w_stray_cyc", ecnt, -1);
      else begin
        e = wq.pop_front();
        chk("w_cyc", ecnt, e.cyc);
        chk("w_val", weight_out, e.val);
      end
    end else chk("weight_out_idle", weight_out, '0);
    if (data_valid) begin
      if (dq.size() == 0) chk("d_stray_cyc", ecnt, -1);
      else begin
        e = dq.pop_front();
        chk("d_cyc", ecnt, e.cyc);
        chk("d_val", data_out, e.val);
      end
    end else chk("data_out_idle", data_out, '0);
    if (done) begin
      if (done_q.size() == 0) chk("done_stray_cyc", ecnt, -1);
      else chk("done_cyc", ecnt, done_q.pop_front());
    end
  end

  task automatic reset_checks(input string tag);
    chk({tag, "_w_ren"}, w_ren, 1'b0);
    chk({tag, "_w_addr"}, w_addr, '0);
    chk({tag, "_d_ren"}, d_ren, 1'b0);
    chk({tag, "_d_addr"}, d_addr, '0);
    chk({tag, "_weight_out"}, weight_out, '0);
    chk({tag, "_weight_valid"}, weight_valid, 1'b0);
    chk({tag, "_data_out"}, data_out, '0);
    chk({tag, "_data_valid"}, data_valid, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
  endtask

  // Called just after a negedge; start is sampled on the next posedge (relative cycle 0).
  task automatic launch(input int r, input int c, output int s);
    exp_t e;
    start  = 1'b1;
    row_in = 9'(r);
    col_in = 9'(c);
    s = ecnt + 1;
    for (int i = 0; i < int'(K); i++) begin
      e.cyc = s + 2 + i;
      e.val = wbeat(i);
      wq.push_back(e);
    end
    for (int p = 0; p < r * c; p++) begin
      e.cyc = s + int'(K) + 2 + GAPC + p;
      e.val = pix(p);
      dq.push_back(e);
    end
    done_q.push_back(s + int'(K) + 2 + GAPC + r * c);
    blo = s + 1;
    bhi = s + int'(K) + 1 + GAPC + r * c;
    @(negedge Clk);
    start = 1'b0;
  endtask

  task automatic wait_until(input int target);
    int n = 0;
    while (ecnt < target && n < 1000) begin
      @(negedge Clk);
      n++;
    end
    chk("wait_cycle", ecnt, target);
  endtask

  task automatic drain();
    int n = 0;
    while ((wq.size() + dq.size() + done_q.size()) != 0 && n < 300) begin
      @(negedge Clk);
      n++;
    end
    chk("drain_pending", wq.size() + dq.size() + done_q.size(), 0);
    repeat (3) @(negedge Clk);
  endtask

  initial begin
    int s;
    // Reset state
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    reset_checks("reset");
    Rst = 1'b1;
    repeat (2) @(negedge Clk);

    // Zero column: start ignored
    start  = 1'b1;
    row_in = 9'd7;
    col_in = 9'd0;
    @(negedge Clk);
    start = 1'b0;
    repeat (20) begin
      @(negedge Clk);
      chk("zero_dim_idle", {w_ren, d_ren, done, busy}, 4'b0);
    end

    // 7x7 with a second start (row 3) at relative cycle 30
    launch(7, 7, s);
    wait_until(s + 29);
    start  = 1'b1;
    row_in = 9'd3;
    col_in = 9'd3;
    @(negedge Clk);
    start = 1'b0;
    drain();
    chk("row_latched", dut.row_q, 9'd7);
    chk("col_latched", dut.col_q, 9'd7);
    chk("last_d_addr", d_addr, AW'(48));

    // Reset in the middle of the data phase
    launch(7, 7, s);
    wait_until(s + 19);
    Rst = 1'b0;
    @(posedge Clk);
    #1;
    wq.delete();
    dq.delete();
    done_q.delete();
    blo = 1;
    bhi = 0;
    @(negedge Clk);
    reset_checks("midrun_reset");
    Rst = 1'b1;
    repeat (20) @(negedge Clk);
    launch(7, 7, s);
    drain();

    // 1x1 picture
    launch(1, 1, s);
    drain();
    chk("d_addr_1x1", d_addr, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
